alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered 16-bit integer ALU for the small 16-bit CPU execute stage.
- Decodes the opcode and function fields of the instruction word directly and computes add/add-with-carry/subtract (register or 5-bit immediate operand), bitwise logic, and shifts.
- The result and carry-out are registered with one cycle of latency.

Parameters:
- WIDTH, 16, data path width. Instruction is always 16 bits. Shift amount uses the low $clog2(WIDTH) bits of regB.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  operands and instruction valid this cycle
- instruction  in  16  full instruction word
- regA  in  WIDTH  first operand (register A read value)
- regA_imm6  in  WIDTH  register A value for the 6-bit-immediate format; interface compatibility only, ignored by all defined ops
- regA_imm8  in  WIDTH  register A value for the 8-bit-immediate format; interface compatibility only, ignored by all defined ops
- regB  in  WIDTH  second operand / shift amount
- carry  in  1  carry flag input, used by ADC
- result  out  WIDTH  registered result
- carry_out  out  1  registered carry/borrow/shift-out flag
- valid_out  out  1  valid_in delayed one cycle

Behaviour:
- Reset (rst=1 at posedge):
  - result=0, carry_out=0, valid_out=0.
  - Flag outputs (when enabled) also reset to 0.
- Latency:
  - On a posedge with valid_in=1, the outputs capture this cycle's computation.
  - With valid_in=0, result and carry_out hold their values; valid_out is 0.
  - valid_out <= valid_in every non-reset cycle.
- Opcode is instruction[15:11]. Immediate select is instruction[5].
- Operand B:
  - If instruction[5]=1, operand B = instruction[4:0] sign-extended to WIDTH.
  - Otherwise operand B = regB.
- 10000 ADD: result = regA + opB; carry_out = bit WIDTH of the sum.
- 10001 ADC: result = regA + opB + carry; carry_out = bit WIDTH of the sum.
- 10010 SUB: result = regA - opB, wraps modulo 2^WIDTH; carry_out = 1 when there is a borrow (unsigned regA < opB).
- 10011 logic/shift group, function select instruction[8:6], using regA and regB (the immediate bit is ignored):
  - 000 AND; 001 OR; 010 NOT (~regA, regB ignored); 011 XOR. For these, carry_out=0.
  - 100 SLL; 101 SRL (zero fill); 110 SRA (sign fill).
  - Shift amount is regB[3:0]; upper regB bits are ignored.
  - Shift carry_out = last bit shifted out; 0 when the amount is 0.
  - 111 is reserved: result=0, carry_out=0.
- Any other opcode: result=0, carry_out=0. No trap.
- Instruction bits not named above are don't-care.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, three extra registered outputs exist, updated under the same valid_in/reset rules as result:
  - zero: 1 when the result is 0.
  - negative: 1 when result[WIDTH-1] is set.
  - overflow: signed overflow, for ADD/ADC/SUB only, else 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants: OP_ADD=5'b10000, OP_ADC=5'b10001, OP_SUB=5'b10010, OP_LOGIC=5'b10011;
  - logic function enum: AND, OR, NOT, XOR, SLL, SRL, SRA;
  - field bit positions.
- One combinational sub-module, alu_shifter, performs SLL/SRL/SRA and the shift-out bit.
- The top level handles decode, add/sub, logic ops and output registers.

Test Plan:
- ADD: regA=10, regB=5, instruction 16'h8001 -> result 15, carry_out 0. Immediate 16'h8021, regB=0 -> 11. ADD regA=16'hFFFF, regB=1 -> result 0, carry_out 1.
- ADC: carry=1, regA=10, regB=5, 16'h8801 -> 16. Immediate 16'h8821 -> 12.
- SUB: regA=10, regB=5, 16'h9001 -> 5. Immediate 16'h9021 -> 9. regA=0, regB=1 -> 16'hFFFF, carry_out 1.
- Logic, regA=10, regB=5:
  - AND 16'h9800 -> 0.
  - OR 16'h9840 -> 15.
  - NOT 16'h9880 -> 16'hFFF5.
  - XOR 16'h98C0 -> 15.
- Shifts:
  - SLL 16'h9900, regA=10, regB=2 -> 40.
  - SRL 16'h9940, regA=10, regB=1 -> 5.
  - SRA 16'h9980, regA=16'hFFF0, regB=1 -> 16'hFFF8.
- Control:
  - rst mid-stream -> result 0 and valid_out 0 on the next edge.
  - valid_in=0 -> result holds the previous value.
  - Each result appears exactly one cycle after its valid_in.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, logic-group function encoding and instruction field positions for alu_core
package alu_pkg;
  localparam logic [4:0] OP_ADD   = 5'b10000;
  localparam logic [4:0] OP_ADC   = 5'b10001;
  localparam logic [4:0] OP_SUB   = 5'b10010;
  localparam logic [4:0] OP_LOGIC = 5'b10011;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int FN_MSB  = 8;
  localparam int FN_LSB  = 6;
  localparam int IMM_BIT = 5;
  localparam int IMM_MSB = 4;
  typedef enum logic [2:0] {
    FN_AND = 3'b000,
    FN_OR  = 3'b001,
    FN_NOT = 3'b010,
    FN_XOR = 3'b011,
    FN_SLL = 3'b100,
    FN_SRL = 3'b101,
    FN_SRA = 3'b110
  } func_e;
  function automatic logic is_arith(logic [4:0] op);
    return op inside {OP_ADD, OP_ADC, OP_SUB};
  endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/instruction bundle into alu_core and its registered results; flag outputs exist only with ALU_FLAGS_EN
interface alu_if #(parameter int WIDTH = 16);
  logic             valid_in;
  logic [15:0]      instruction;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regA_imm6;
  logic [WIDTH-1:0] regA_imm8;
  logic [WIDTH-1:0] regB;
  logic             carry;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             valid_out;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;
  modport master (output valid_in, instruction, regA, regA_imm6, regA_imm8, regB, carry,
                  input result, carry_out, valid_out, zero, negative, overflow);
  modport slave  (input valid_in, instruction, regA, regA_imm6, regA_imm8, regB, carry,
                  output result, carry_out, valid_out, zero, negative, overflow);
`else
  modport master (output valid_in, instruction, regA, regA_imm6, regA_imm8, regB, carry,
                  input result, carry_out, valid_out);
  modport slave  (input valid_in, instruction, regA, regA_imm6, regA_imm8, regB, carry,
                  output result, carry_out, valid_out);
`endif
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational SLL/SRL/SRA with the last bit shifted out (0 for a zero amount)
module alu_shifter import alu_pkg::*; #(
  parameter int WIDTH = 16,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SW-1:0]    amt_i,
  input  func_e            fn_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o
);
  logic [WIDTH:0] l, rl;
  logic signed [WIDTH:0] ra;
  // one guard bit beyond each end catches the shifted-out bit and reads 0 when nothing moves
  always_comb begin
    l = {1'b0, a_i} << amt_i;
    rl = {a_i, 1'b0} >> amt_i;
    ra = $signed({a_i, 1'b0}) >>> amt_i;
    res_o = fn_i == FN_SLL ? l[WIDTH-1:0] : fn_i == FN_SRA ? ra[WIDTH:1] : rl[WIDTH:1];
    c_o = fn_i == FN_SLL ? l[WIDTH] : fn_i == FN_SRA ? ra[0] : rl[0];
  end
endmodule

// File: rtl/alu_core.sv
// alu_core: registered 16-bit execute-stage ALU (add/adc/sub, logic, shifts); ALU_FLAGS_EN adds zero/negative/overflow outputs
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  logic [4:0] opcode;
  func_e fn;
  logic [WIDTH-1:0] a, b, op_b, sh_res, res_d, result_q;
  logic [WIDTH:0] sum;
  logic sh_c, c_d, carry_q, valid_q, unused_ok;
  assign opcode = bus.instruction[OPC_MSB:OPC_LSB];
  assign fn = func_e'(bus.instruction[FN_MSB:FN_LSB]);
  assign a = bus.regA;
  assign b = bus.regB;
  assign op_b = bus.instruction[IMM_BIT] ? {{(WIDTH-5){bus.instruction[IMM_MSB]}}, bus.instruction[IMM_MSB:0]} : b;
  assign unused_ok = ^{bus.regA_imm6, bus.regA_imm8, bus.instruction[10:9]};
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a_i(a), .amt_i(b[SW-1:0]), .fn_i(fn), .res_o(sh_res), .c_o(sh_c)
  );
  // the extra top bit of sum is carry-out for adds and borrow for subtract
  always_comb begin
    sum = opcode == OP_SUB ? {1'b0, a} - {1'b0, op_b}
                           : {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, opcode == OP_ADC && bus.carry};
    res_d = '0;
    c_d = 1'b0;
    if (is_arith(opcode)) begin
      res_d = sum[WIDTH-1:0];
      c_d = sum[WIDTH];
    end else if (opcode == OP_LOGIC) begin
      res_d = fn == FN_AND ? a & b : fn == FN_OR ? a | b : fn == FN_NOT ? ~a : fn == FN_XOR ? a ^ b
            : fn inside {FN_SLL, FN_SRL, FN_SRA} ? sh_res : '0;
      c_d = fn inside {FN_SLL, FN_SRL, FN_SRA} && sh_c;
    end
  end
`ifdef ALU_FLAGS_EN
  logic ov_d, zero_q, neg_q, ov_q;
  // signed overflow: operand signs (B inverted for subtract) agree but the result sign differs
  always_comb begin
    ov_d = is_arith(opcode) && (a[WIDTH-1] ^ op_b[WIDTH-1]) == (opcode == OP_SUB) && sum[WIDTH-1] != a[WIDTH-1];
  end
  // flags follow the same capture rules as result
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (bus.valid_in) begin
      zero_q <= res_d == '0;
      neg_q <= res_d[WIDTH-1];
      ov_q <= ov_d;
    end
  end
  assign bus.zero = zero_q;
  assign bus.negative = neg_q;
  assign bus.overflow = ov_q;
`endif
  // capture on valid_in, hold otherwise; valid_out is valid_in one cycle late
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        result_q <= res_d;
        carry_q <= c_d;
      end
    end
  end
  assign bus.result = result_q;
  assign bus.carry_out = carry_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against an arithmetic reference model
module tb_alu_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_res = '0;
  logic exp_c = 1'b0, exp_v = 1'b0;
  logic exp_z = 1'b0, exp_n = 1'b0, exp_ov = 1'b0;
  alu_if #(.WIDTH(16)) bus ();
  alu_core #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] r, output logic c, output logic ov);
    int ai, bi, sa, sb, s, n, fn;
    int si;
    si = $signed(ins[4:0]);
    ai = a;
    bi = ins[5] ? (si & 'hFFFF) : b;
    sa = $signed(a);
    sb = $signed(bi[15:0]);
    n = b[3:0];
    fn = ins[8:6];
    r = '0; c = 1'b0; ov = 1'b0; s = 0;
    case (ins[15:11])
      5'b10000, 5'b10001: begin
        s = ai + bi + ((ins[15:11] == 5'b10001) ? int'(cin) : 0);
        r = s[15:0]; c = s[16];
        s = sa + sb + ((ins[15:11] == 5'b10001) ? int'(cin) : 0);
        ov = s > 32767 || s < -32768;
      end
      5'b10010: begin
        s = ai - bi;
        r = s[15:0]; c = ai < bi;
        s = sa - sb;
        ov = s > 32767 || s < -32768;
      end
      5'b10011: begin
        case (fn)
          0: r = a & b;
          1: r = a | b;
          2: r = ~a;
          3: r = a ^ b;
          4: begin s = ai << n; r = s[15:0]; c = n != 0 && s[16]; end
          5: begin s = ai >> n; r = s[15:0]; c = n != 0 && ((ai >> (n - 1)) & 1) != 0; end
          6: begin s = sa >>> n; r = s[15:0]; c = n != 0 && ((ai >> (n - 1)) & 1) != 0; end
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
  endtask

  task automatic compare(input string tag);
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".carry"}, bus.carry_out, exp_c);
    check({tag, ".valid"}, bus.valid_out, exp_v);
`ifdef ALU_FLAGS_EN
    check({tag, ".zero"}, bus.zero, exp_z);
    check({tag, ".neg"}, bus.negative, exp_n);
    check({tag, ".ovf"}, bus.overflow, exp_ov);
`endif
  endtask

  task automatic go(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] a,
                    input logic [15:0] b, input logic cin, input logic r);
    logic [15:0] mr;
    logic mc, mov;
    @(negedge clk);
    rst = r;
    bus.valid_in = v;
    bus.instruction = ins;
    bus.regA = a;
    bus.regB = b;
    bus.carry = cin;
    bus.regA_imm6 = 16'($urandom);
    bus.regA_imm8 = 16'($urandom);
    #1 check({tag, ".pre"}, bus.result, exp_res);
    model(ins, a, b, cin, mr, mc, mov);
    @(posedge clk);
    if (r) begin
      exp_res = '0; exp_c = 1'b0; exp_v = 1'b0; exp_z = 1'b0; exp_n = 1'b0; exp_ov = 1'b0;
    end else begin
      exp_v = v;
      if (v) begin
        exp_res = mr; exp_c = mc; exp_z = mr == 16'h0; exp_n = mr[15]; exp_ov = mov;
      end
    end
    #1 compare(tag);
  endtask

  initial begin
    logic [15:0] ins;
    logic [4:0] ops[5];
    bus.valid_in = 1'b0;
    bus.instruction = '0;
    bus.regA = '0;
    bus.regB = '0;
    bus.carry = 1'b0;
    bus.regA_imm6 = '0;
    bus.regA_imm8 = '0;
    repeat (2) @(posedge clk);
    #1 compare("reset");
    go("add", 1, 16'h8001, 16'd10, 16'd5, 0, 0);
    check("add15", bus.result, 16'd15);
    go("addi", 1, 16'h8021, 16'd10, 16'd0, 0, 0);
    check("addi11", bus.result, 16'd11);
    go("addwrap", 1, 16'h8001, 16'hFFFF, 16'd1, 0, 0);
    check("addwrap_c", {bus.carry_out, bus.result}, 17'h10000);
    go("adc", 1, 16'h8801, 16'd10, 16'd5, 1, 0);
    check("adc16", bus.result, 16'd16);
    go("adci", 1, 16'h8821, 16'd10, 16'd5, 1, 0);
    check("adci12", bus.result, 16'd12);
    go("sub", 1, 16'h9001, 16'd10, 16'd5, 0, 0);
    check("sub5", bus.result, 16'd5);
    go("subi", 1, 16'h9021, 16'd10, 16'd5, 0, 0);
    check("subi9", bus.result, 16'd9);
    go("subb", 1, 16'h9001, 16'd0, 16'd1, 0, 0);
    check("subb_c", {bus.carry_out, bus.result}, 17'h1FFFF);
    go("and", 1, 16'h9800, 16'd10, 16'd5, 0, 0);
    go("or", 1, 16'h9840, 16'd10, 16'd5, 0, 0);
    go("not", 1, 16'h9880, 16'd10, 16'd5, 0, 0);
    check("notFFF5", bus.result, 16'hFFF5);
    go("xor", 1, 16'h98C0, 16'd10, 16'd5, 0, 0);
    go("sll", 1, 16'h9900, 16'd10, 16'd2, 0, 0);
    check("sll40", bus.result, 16'd40);
    go("srl", 1, 16'h9940, 16'd10, 16'd1, 0, 0);
    check("srl5", bus.result, 16'd5);
    go("sra", 1, 16'h9980, 16'hFFF0, 16'd1, 0, 0);
    check("sraFFF8", bus.result, 16'hFFF8);
    go("sll0", 1, 16'h9900, 16'h8001, 16'h0010, 0, 0);
    go("rsvd", 1, 16'h99C0, 16'hFFFF, 16'd3, 1, 0);
    go("badop", 1, 16'h0001, 16'd10, 16'd5, 1, 0);
    go("setup", 1, 16'h8001, 16'd1, 16'd2, 0, 0);
    go("hold", 0, 16'h8001, 16'd7, 16'd7, 0, 0);
    check("hold3", bus.result, 16'd3);
    go("midrst", 1, 16'h8001, 16'd9, 16'd9, 0, 1);
    check("midrst0", {bus.valid_out, bus.result}, 17'h0);
    ops = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b00000};
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 9) != 0) ins[15:11] = ops[$urandom_range(0, 3)];
      go("rand", $urandom_range(0, 3) != 0, ins, 16'($urandom), 16'($urandom), 1'($urandom),
         $urandom_range(0, 39) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
